servo_ramp_ctrl: RTL and testbench

- Motion controller that drives the duty inputs of N_CH servo PWM generators.
- Accepts per-channel target/step commands from the Wishbone register side.
- Once per servo frame, moves each channel's duty toward its target by a bounded step. This limits slew for the cube gripper/rotator servos.
- Presents a fixed period value and per-channel duty values to the PWM generators.

---
 rtl/pwm_servo_pkg.sv | 42 ++++
 rtl/servo_frame_timer.sv | 29 ++
 rtl/servo_ramp_ctrl.sv | 153 +++++++++++++++
 tb/tb_servo_ramp_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_servo_pkg.sv
// rtl/pwm_servo_pkg.sv - shared types, defaults and duty arithmetic for the servo ramp controller
package pwm_servo_pkg;

  localparam int unsigned DUTY_W     = 32;
  localparam int unsigned DEF_PERIOD = 2000000;
  localparam int unsigned DEF_D_MIN  = 100000;
  localparam int unsigned DEF_D_MAX  = 200000;
  localparam int unsigned DEF_D_INIT = 150000;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // Limit a requested duty to the legal servo pulse window.
  function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  // Next duty after one frame: move toward tgt by at most step (0 = jump).
  // Differences are compared before the add/subtract so nothing can wrap.
  function automatic duty_t ramp_next(input duty_t cur, input duty_t tgt, input duty_t step);
    if (step == '0) begin
      return tgt;
    end else if (cur < tgt) begin
      return ((tgt - cur) <= step) ? tgt : (cur + step);
    end else if (cur > tgt) begin
      return ((cur - tgt) <= step) ? tgt : (cur - step);
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running servo frame counter with end-of-frame tick
module servo_frame_timer
  import pwm_servo_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic res,
  input  logic enable,
  output logic frame_tick
);

  localparam logic [31:0] LAST = 32'(PERIOD - 1);

  logic [31:0] cnt;

  // Count 0..PERIOD-1 and wrap; a low enable freezes the count in place.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 32'd1;
    end
  end

  // Gated by enable so a frozen counter parked on the last value cannot re-tick.
  assign frame_tick = enable && (cnt == LAST);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - per-channel slew-limited duty ramping for servo PWM generators
module servo_ramp_ctrl
  import pwm_servo_pkg::*;
#(
  parameter int unsigned N_CH   = 5,
  parameter int unsigned PERIOD = DEF_PERIOD,
  parameter int unsigned D_MIN  = DEF_D_MIN,
  parameter int unsigned D_MAX  = DEF_D_MAX,
  parameter int unsigned D_INIT = DEF_D_INIT
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   enable,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_ch,
  input  logic [31:0]            cmd_target,
  input  logic [31:0]            cmd_step,
  output logic [31:0]            t,
  output logic [32*N_CH-1:0]     d_flat,
  output logic [N_CH-1:0]        busy,
  output logic                   done,
  output logic [2:0]             done_ch,
  output logic                   frame_tick
);

  localparam duty_t      MIN_W    = duty_t'(D_MIN);
  localparam duty_t      MAX_W    = duty_t'(D_MAX);
  localparam duty_t      INIT_W   = duty_t'(D_INIT);
  localparam logic [2:0] IDX_LAST = 3'(N_CH - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic       cmd_fire;

  duty_t cur  [N_CH];
  duty_t tgt  [N_CH];
  duty_t step [N_CH];

  duty_t sel_cur;
  duty_t sel_tgt;
  duty_t sel_step;
  duty_t upd_next;
  duty_t cmd_tgt_clamped;

  servo_frame_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk        (clk),
    .res        (res),
    .enable     (enable),
    .frame_tick (frame_tick)
  );

  assign t = 32'(PERIOD);

  // State and sweep index register.
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // IDLE takes commands and waits for a tick; UPDATE walks one channel per cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cmd_ready = 1'b0;
    cmd_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = cmd_valid;
        if (frame_tick) begin
          state_nxt = UPDATE;
          idx_nxt   = '0;
        end
      end
      UPDATE: begin
        if (idx == IDX_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Pick out the channel being swept this cycle and compute its next duty.
  always_comb begin
    sel_cur  = '0;
    sel_tgt  = '0;
    sel_step = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (idx == 3'(k)) begin
        sel_cur  = cur[k];
        sel_tgt  = tgt[k];
        sel_step = step[k];
      end
    end
    upd_next        = ramp_next(sel_cur, sel_tgt, sel_step);
    cmd_tgt_clamped = clamp_duty(cmd_target, MIN_W, MAX_W);
  end

  // Channel register file: command writes in IDLE, ramp writes in UPDATE.
  // Channel indices outside 0..N_CH-1 match no k, so such commands vanish.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        cur[k]  <= INIT_W;
        tgt[k]  <= INIT_W;
        step[k] <= '0;
      end
      busy    <= '0;
      done    <= 1'b0;
      done_ch <= '0;
    end else begin
      done <= 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        if (cmd_fire && (cmd_ch == 3'(k))) begin
          tgt[k]  <= cmd_tgt_clamped;
          step[k] <= cmd_step;
          busy[k] <= (cur[k] != cmd_tgt_clamped);
        end
        if ((state == UPDATE) && (idx == 3'(k))) begin
          cur[k] <= upd_next;
          if (busy[k] && (upd_next == sel_tgt)) begin
            busy[k] <= 1'b0;
            done    <= 1'b1;
            done_ch <= idx;
          end
        end
      end
    end
  end

  // Flatten the duty registers for the PWM generators.
  for (genvar g = 0; g < int'(N_CH); g++) begin : g_dflat
    assign d_flat[32*g +: 32] = cur[g];
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb/tb_servo_ramp_ctrl.sv - self-checking bench for servo_ramp_ctrl
module tb_servo_ramp_ctrl;

  localparam int N_CH   = 5;
  localparam int PERIOD = 1000;

  logic              clk = 1'b0;
  logic              res;
  logic              enable;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_ch;
  logic [31:0]       cmd_target;
  logic [31:0]       cmd_step;
  logic [31:0]       t;
  logic [32*N_CH-1:0] d_flat;
  logic [N_CH-1:0]   busy;
  logic              done;
  logic [2:0]        done_ch;
  logic              frame_tick;

  servo_ramp_ctrl #(
    .N_CH   (N_CH),
    .PERIOD (PERIOD)
  ) dut (
    .clk        (clk),
    .res        (res),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .t          (t),
    .d_flat     (d_flat),
    .busy       (busy),
    .done       (done),
    .done_ch    (done_ch),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] duty(input int k);
    return d_flat[32*k +: 32];
  endfunction

  // ---------------- behavioural model ----------------
  longint m_cur  [N_CH];
  longint m_tgt  [N_CH];
  longint m_step [N_CH];
  bit     m_busy [N_CH];
  int     m_cnt;
  int     m_left;
  bit     m_done;
  int     m_done_ch;
  int     m_ch;
  longint m_diff;
  longint m_mag;
  longint m_req;

  always @(posedge clk) begin
    if (res) begin
      for (int k = 0; k < N_CH; k++) begin
        m_cur[k] = 150000; m_tgt[k] = 150000; m_step[k] = 0; m_busy[k] = 0;
      end
      m_cnt = 0; m_left = 0; m_done = 0; m_done_ch = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_ch   = N_CH - m_left;
        m_diff = m_tgt[m_ch] - m_cur[m_ch];
        m_mag  = (m_diff < 0) ? -m_diff : m_diff;
        if (m_step[m_ch] == 0 || m_mag <= m_step[m_ch]) m_cur[m_ch] = m_tgt[m_ch];
        else if (m_diff > 0) m_cur[m_ch] = m_cur[m_ch] + m_step[m_ch];
        else m_cur[m_ch] = m_cur[m_ch] - m_step[m_ch];
        if (m_busy[m_ch] && m_cur[m_ch] == m_tgt[m_ch]) begin
          m_busy[m_ch] = 0; m_done = 1; m_done_ch = m_ch;
        end
        m_left--;
      end else begin
        if (cmd_valid && int'(cmd_ch) < N_CH) begin
          m_req = cmd_target;
          if (m_req < 100000) m_req = 100000;
          if (m_req > 200000) m_req = 200000;
          m_tgt[cmd_ch]  = m_req;
          m_step[cmd_ch] = cmd_step;
          m_busy[cmd_ch] = (m_cur[cmd_ch] != m_req);
        end
        if (enable && m_cnt == PERIOD - 1) m_left = N_CH;
      end
      if (enable) m_cnt = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int done_q[$];
  int cyc       = 0;
  int last_tick = -1;
  int tick_gap  = 0;
  logic [N_CH-1:0] m_busy_vec;

  always begin
    @(negedge clk);
    #1;
    if (started) begin
      cyc++;
      for (int k = 0; k < N_CH; k++) m_busy_vec[k] = m_busy[k];
      check("t", t, PERIOD);
      check("cmd_ready", cmd_ready, (m_left == 0));
      check("frame_tick", frame_tick, (enable && m_cnt == PERIOD - 1));
      check("busy", busy, m_busy_vec);
      check("done", done, m_done);
      if (m_done) check("done_ch", done_ch, m_done_ch);
      for (int k = 0; k < N_CH; k++) check($sformatf("duty%0d", k), duty(k), m_cur[k]);
      if (done) done_q.push_back(int'(done_ch));
      if (frame_tick) begin
        if (last_tick >= 0) tick_gap = cyc - last_tick;
        last_tick = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [2:0] ch, input logic [31:0] tg, input logic [31:0] st);
    int n = 0;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_target = tg; cmd_step = st;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!frame_tick && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", frame_tick, 1);
  endtask

  task automatic run_frame();
    wait_tick();
    repeat (N_CH + 2) @(negedge clk);
  endtask

  int n;
  int ticks;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; enable = 1'b1; cmd_valid = 1'b0;
    cmd_ch = '0; cmd_target = '0; cmd_step = '0;
    @(negedge clk);
    started = 1'b1;
    for (int k = 0; k < N_CH; k++) check("rst_duty", duty(k), 150000);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_done_ch", done_ch, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_t", t, 1000);
    repeat (2) @(negedge clk);
    res = 1'b0;

    // idle frames, no commands
    run_frame();
    run_frame();
    check("tick_gap", tick_gap, 1000);
    check("idle_done_count", done_q.size(), 0);
    for (int k = 0; k < N_CH; k++) check("idle_duty", duty(k), 150000);

    // ch2 ramp 150000 -> 160000 by 4000
    done_q.delete();
    send_cmd(3'd2, 32'd160000, 32'd4000);
    check("ch2_busy_set", busy[2], 1);
    run_frame();
    check("ch2_f1", duty(2), 154000);
    check("ch2_busy_f1", busy[2], 1);
    run_frame();
    check("ch2_f2", duty(2), 158000);
    check("ch2_busy_f2", busy[2], 1);
    check("ch2_nodone_yet", done_q.size(), 0);
    run_frame();
    check("ch2_f3", duty(2), 160000);
    check("ch2_busy_f3", busy[2], 0);
    check("ch2_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("ch2_done_ch", done_q[0], 2);

    // ch0 clamped jump
    done_q.delete();
    send_cmd(3'd0, 32'd50000, 32'd0);
    run_frame();
    check("ch0_clamp", duty(0), 100000);
    check("ch0_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("ch0_done_ch", done_q[0], 0);

    // command in tick cycle, then command held across the sweep
    done_q.delete();
    wait_tick();
    cmd_valid = 1'b1; cmd_ch = 3'd4; cmd_target = 32'd120000; cmd_step = 32'd0;
    @(negedge clk);
    cmd_ch = 3'd3; cmd_target = 32'd180000; cmd_step = 32'd0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", n, N_CH);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("tick_cmd_ch4", duty(4), 120000);
    check("held_cmd_ch3_wait", duty(3), 150000);
    check("held_cmd_busy3", busy[3], 1);
    check("tick_cmd_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("tick_cmd_done_ch", done_q[0], 4);
    run_frame();
    check("held_cmd_ch3", duty(3), 180000);
    check("held_done_count", done_q.size(), 2);
    if (done_q.size() > 1) check("held_done_ch", done_q[1], 3);

    // override mid-ramp on ch1
    done_q.delete();
    send_cmd(3'd1, 32'd190000, 32'd10000);
    run_frame();
    check("ovr_up1", duty(1), 160000);
    run_frame();
    check("ovr_up2", duty(1), 170000);
    send_cmd(3'd1, 32'd150000, 32'd5000);
    for (int i = 0; i < 4; i++) begin
      run_frame();
      check($sformatf("ovr_down%0d", i), duty(1), 165000 - 5000 * i);
      check($sformatf("ovr_done_count%0d", i), done_q.size(), (i == 3) ? 1 : 0);
    end
    if (done_q.size() > 0) check("ovr_done_ch", done_q[0], 1);

    // enable dropped mid-sweep: sweep finishes, no further ticks
    send_cmd(3'd4, 32'd130000, 32'd5000);
    wait_tick();
    @(negedge clk);
    enable = 1'b0;
    repeat (N_CH + 2) @(negedge clk);
    check("en_sweep_completes", duty(4), 125000);
    ticks = 0;
    repeat (1500) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    check("en_no_ticks", ticks, 0);
    check("en_frozen_duty", duty(4), 125000);
    enable = 1'b1;

    // reset during a sweep after partial ramps
    send_cmd(3'd0, 32'd110000, 32'd1000);
    send_cmd(3'd2, 32'd200000, 32'd1000);
    wait_tick();
    repeat (2) @(negedge clk);
    check("pre_rst_ch0", duty(0), 101000);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    for (int k = 0; k < N_CH; k++) check("mid_rst_duty", duty(k), 150000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    done_q.delete();
    send_cmd(3'd7, 32'd190000, 32'd0);
    check("ch7_busy", busy, 0);
    run_frame();
    for (int k = 0; k < N_CH; k++) check("ch7_duty", duty(k), 150000);
    check("ch7_done_count", done_q.size(), 0);
    check("ch7_busy_after", busy, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
